// File: rtl/power_switch_emu.sv
// Power-domain switch emulator: per-channel ON/GOING_OFF/OFF/GOING_ON state machine.
// Each channel acknowledges requests after a programmable latency and can be fault-forced.
module power_switch_emu #(
  parameter int unsigned               NUM_CH    = 2,
  parameter int unsigned               MAX_LAT   = 64,
  parameter logic [NUM_CH*32-1:0]      ON_LAT    = {NUM_CH{32'd16}},
  parameter logic [NUM_CH*32-1:0]      OFF_LAT   = {NUM_CH{32'd16}},
  parameter logic [NUM_CH-1:0]         RST_ACK_N = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NUM_CH-1:0] switch_n_i,
  input  logic [NUM_CH-1:0] force_i,
  input  logic [NUM_CH-1:0] force_val_i,
  output logic [NUM_CH-1:0] ack_n_o,
  output logic [NUM_CH-1:0] busy_o,
  output logic [NUM_CH-1:0] abort_o
);

  localparam int unsigned CW = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  typedef enum logic [1:0] {
    ST_ON,
    ST_GOING_OFF,
    ST_OFF,
    ST_GOING_ON
  } state_e;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lat_chk
    if (ON_LAT[g*32 +: 32] < 32'd1 || ON_LAT[g*32 +: 32] > MAX_LAT) begin : g_bad_on
      $error("power_switch_emu: ON_LAT entry out of range 1..MAX_LAT");
    end
    if (OFF_LAT[g*32 +: 32] < 32'd1 || OFF_LAT[g*32 +: 32] > MAX_LAT) begin : g_bad_off
      $error("power_switch_emu: OFF_LAT entry out of range 1..MAX_LAT");
    end
  end

  state_e              state_q [NUM_CH];
  state_e              state_d [NUM_CH];
  logic   [CW-1:0]     cnt_q   [NUM_CH];
  logic   [CW-1:0]     cnt_d   [NUM_CH];
  logic   [NUM_CH-1:0] ack_q, ack_d;
  logic   [NUM_CH-1:0] busy_q, busy_d;
  logic   [NUM_CH-1:0] abort_q, abort_d;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      abort_d[i] = 1'b0;

      // A forced channel freezes its state machine; only the ack is overridden.
      if (!force_i[i]) begin
        unique case (state_q[i])
          ST_ON: begin
            if (switch_n_i[i]) begin
              if (OFF_LAT[i*32 +: 32] == 32'd1) begin
                state_d[i] = ST_OFF;
              end else begin
                state_d[i] = ST_GOING_OFF;
                cnt_d[i]   = CW'(OFF_LAT[i*32 +: 32] - 32'd2);
              end
            end
          end
          ST_GOING_OFF: begin
            if (!switch_n_i[i]) begin
              state_d[i] = ST_ON;
              abort_d[i] = 1'b1;
            end else if (cnt_q[i] == '0) begin
              state_d[i] = ST_OFF;
            end else begin
              cnt_d[i] = cnt_q[i] - CW'(1);
            end
          end
          ST_OFF: begin
            if (!switch_n_i[i]) begin
              if (ON_LAT[i*32 +: 32] == 32'd1) begin
                state_d[i] = ST_ON;
              end else begin
                state_d[i] = ST_GOING_ON;
                cnt_d[i]   = CW'(ON_LAT[i*32 +: 32] - 32'd2);
              end
            end
          end
          ST_GOING_ON: begin
            if (switch_n_i[i]) begin
              state_d[i] = ST_OFF;
              abort_d[i] = 1'b1;
            end else if (cnt_q[i] == '0) begin
              state_d[i] = ST_ON;
            end else begin
              cnt_d[i] = cnt_q[i] - CW'(1);
            end
          end
          default: state_d[i] = ST_ON;
        endcase
      end

      ack_d[i]  = force_i[i] ? force_val_i[i]
                             : (state_d[i] == ST_OFF || state_d[i] == ST_GOING_ON);
      busy_d[i] = (state_d[i] == ST_GOING_OFF || state_d[i] == ST_GOING_ON);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: the per-channel state arrays are small control registers, so all of them are reset.
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= RST_ACK_N[i] ? ST_OFF : ST_ON;
        cnt_q[i]   <= '0;
      end
      ack_q   <= RST_ACK_N;
      busy_q  <= '0;
      abort_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      abort_q <= abort_d;
    end
  end

  assign ack_n_o = ack_q;
  assign busy_o  = busy_q;
  assign abort_o = abort_q;

endmodule

// File: tb/tb_power_switch_emu.sv
// Randomized scoreboard bench for power_switch_emu: a level/pending/countdown reference
// model predicts each edge's outputs, and a monitor compares them after every rising edge.
module tb_power_switch_emu;

  localparam int N = 4;
  // ch3..ch0
  localparam logic [N*32-1:0] ON_LAT    = {32'd2, 32'd1, 32'd9, 32'd4};
  localparam logic [N*32-1:0] OFF_LAT   = {32'd1, 32'd3, 32'd16, 32'd1};
  localparam logic [N-1:0]    RST_ACK_N = 4'b1010;

  localparam int ON_L  [N] = '{4, 9, 1, 2};
  localparam int OFF_L [N] = '{1, 16, 3, 1};

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic [N-1:0] switch_n_i, force_i, force_val_i;
  logic [N-1:0] ack_n_o, busy_o, abort_o;

  power_switch_emu #(
    .NUM_CH(N), .MAX_LAT(16), .ON_LAT(ON_LAT), .OFF_LAT(OFF_LAT), .RST_ACK_N(RST_ACK_N)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .switch_n_i(switch_n_i), .force_i(force_i),
    .force_val_i(force_val_i), .ack_n_o(ack_n_o), .busy_o(busy_o), .abort_o(abort_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [N-1:0] ack;
    logic [N-1:0] busy;
    logic [N-1:0] abort;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s @%0t: actual=%h required=%h", nm, $time, act, req);
  endtask

  // Reference model: settled level (1 = unpowered), pending request flag and
  // number of further edges until the ack flips.
  logic lvl  [N];
  logic pend [N];
  int   rem  [N];
  logic [N-1:0] m_ack, m_busy, m_abort;

  function automatic int lat_for(int ch, logic to_off);
    return to_off ? OFF_L[ch] : ON_L[ch];
  endfunction

  task automatic model_edge();
    for (int c = 0; c < N; c++) begin
      m_abort[c] = 1'b0;
      if (!rst_ni) begin
        lvl[c]  = RST_ACK_N[c];
        pend[c] = 1'b0;
        rem[c]  = 0;
        m_ack[c] = RST_ACK_N[c];
      end else if (force_i[c]) begin
        m_ack[c] = force_val_i[c];
      end else begin
        if (!pend[c]) begin
          if (switch_n_i[c] != lvl[c]) begin
            if (lat_for(c, switch_n_i[c]) == 1) lvl[c] = switch_n_i[c];
            else begin
              pend[c] = 1'b1;
              rem[c]  = lat_for(c, switch_n_i[c]) - 1;
            end
          end
        end else if (switch_n_i[c] == lvl[c]) begin
          pend[c]    = 1'b0;
          m_abort[c] = 1'b1;
        end else begin
          rem[c]--;
          if (rem[c] == 0) begin
            lvl[c]  = switch_n_i[c];
            pend[c] = 1'b0;
          end
        end
        m_ack[c] = lvl[c];
      end
      m_busy[c] = pend[c];
    end
    exp_q.push_back('{ack: m_ack, busy: m_busy, abort: m_abort});
  endtask

  // Monitor: one expected entry per rising edge, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("ack_n",  32'(ack_n_o), 32'(e.ack));
        check("busy",   32'(busy_o),  32'(e.busy));
        check("abort",  32'(abort_o), 32'(e.abort));
      end
    end
  end

  int hold      [N];
  int frc_left  [N];

  initial begin
    rst_ni      = 1'b0;
    switch_n_i  = RST_ACK_N;
    force_i     = '0;
    force_val_i = '0;
    for (int c = 0; c < N; c++) begin
      hold[c]     = 25;
      frc_left[c] = 0;
    end

    for (int cyc = 0; cyc < 1500; cyc++) begin
      logic rst_rise;
      @(negedge clk_i);
      rst_rise = 1'b0;
      if (cyc == 3 || cyc == 402 || cyc == 905) rst_ni = 1'b1;
      if (cyc == 400 || cyc == 903) begin
        rst_ni   = 1'b0;
        rst_rise = 1'b1;
      end

      if (cyc == 10) begin
        switch_n_i = ~switch_n_i;  // all channels switch on the same edge
      end else if (cyc > 40) begin
        for (int c = 0; c < N; c++) begin
          if (hold[c] == 0) begin
            switch_n_i[c] = ~switch_n_i[c];
            hold[c]       = $urandom_range(1, 20);
          end else begin
            hold[c]--;
          end
          if (frc_left[c] != 0) frc_left[c]--;
          else if ($urandom_range(0, 29) == 0) frc_left[c] = $urandom_range(1, 12);
          force_i[c]     = (frc_left[c] != 0);
          force_val_i[c] = 1'($urandom_range(0, 1));
        end
      end

      model_edge();

      if (rst_rise) begin
        #1;
        check("async_rst_ack",   32'(ack_n_o), 32'(RST_ACK_N));
        check("async_rst_busy",  32'(busy_o),  32'd0);
        check("async_rst_abort", 32'(abort_o), 32'd0);
      end
    end

    for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(posedge clk_i);
    #2;
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/power_switch_emu.md
POWER_SWITCH_EMU -- requirements
Module: power_switch_emu

Interface
REQ-001 Parameter NUM_CH, default 2: number of independent power-domain switch channels (1..32).
REQ-002 Parameter MAX_LAT, default 64: upper bound on any latency; counter width is $clog2(MAX_LAT).
REQ-003 Parameter ON_LAT, default all channels 16: per-channel power-on ack latency in cycles, NUM_CH x 32-bit packed, each 1..MAX_LAT.
REQ-004 Parameter OFF_LAT, default all channels 16: per-channel power-off ack latency in cycles, same format and range as ON_LAT.
REQ-005 Parameter RST_ACK_N, default '0 (NUM_CH bits): per-channel state after reset; 0 = powered (ON), 1 = unpowered (OFF).
REQ-006 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-007 rst_ni  input  1  reset, asynchronous and active-low.
REQ-008 switch_n_i  input  NUM_CH  switch request per channel; 0 = power on, 1 = power off.
REQ-009 force_i  input  NUM_CH  fault-injection enable per channel.
REQ-010 force_val_i  input  NUM_CH  ack value driven while the channel is forced.
REQ-011 ack_n_o  output  NUM_CH  registered switch ack per channel; 0 = domain powered.
REQ-012 busy_o  output  NUM_CH  1 while the channel is in GOING_OFF or GOING_ON.
REQ-013 abort_o  output  NUM_CH  one-cycle pulse when an in-flight transition is cancelled.
REQ-014 Any ON_LAT/OFF_LAT entry outside 1..MAX_LAT SHALL raise an elaboration-time error.

Function
REQ-015 Each channel SHALL run an independent FSM with states ON, GOING_OFF, OFF, GOING_ON and a down-counter cnt.
REQ-016 In ON with switch_n_i=1: if OFF_LAT=1, go to OFF; else go to GOING_OFF with cnt<=OFF_LAT-2.
REQ-017 In GOING_OFF: if switch_n_i=0, go to ON and pulse abort_o; else if cnt=0, go to OFF; else decrement cnt.
REQ-018 In OFF with switch_n_i=0: if ON_LAT=1, go to ON; else go to GOING_ON with cnt<=ON_LAT-2.
REQ-019 In GOING_ON: if switch_n_i=1, go to OFF and pulse abort_o; else if cnt=0, go to ON; else decrement cnt.
REQ-020 Unforced, ack_n_o SHALL be registered as 1 iff the next state is OFF or GOING_ON, else 0.
REQ-021 Latency: if edge k is the first edge sampling a new switch_n_i level, ack_n_o SHALL change at edge k+L-1, where L is the channel's ON_LAT or OFF_LAT.
REQ-022 A request glitch shorter than L cycles SHALL leave ack_n_o unchanged and produce exactly one abort_o pulse.
REQ-023 With force_i=1 sampled at an edge: ack_n_o<=force_val_i, FSM state and cnt hold, and abort_o stays 0.
REQ-024 On the first edge with force_i=0 after forcing, ack_n_o SHALL resume per REQ-020 from the held state.
REQ-025 busy_o SHALL be registered and reflect the current state (GOING_OFF or GOING_ON).
REQ-026 abort_o SHALL be registered, high for exactly the cycle after the cancelling edge.
REQ-027 Channels SHALL NOT interact; simultaneous events on different channels are handled independently.

Reset
REQ-028 While rst_ni=0, per channel: state=ON if RST_ACK_N=0 else OFF; cnt=0; ack_n_o=RST_ACK_N; busy_o=0; abort_o=0.
REQ-029 Reset asserted mid-transition SHALL discard the transition with no abort_o pulse.
REQ-030 After reset release, the first edge SHALL evaluate the FSM normally against the current switch_n_i.

Verification
REQ-031 Defaults, ch0 switch_n_i 0->1 before edge k -> ack_n_o[0] rises at edge k+15, busy_o[0] high for cycles k..k+14, ch1 unchanged.
REQ-032 OFF_LAT[0]=1, switch_n_i[0] 0->1 -> ack_n_o[0]=1 at the first sampling edge, busy_o[0] never asserted.
REQ-033 ON_LAT=16, ch0 OFF, switch_n_i[0] low for 5 cycles then high -> ack_n_o[0] stays 1, one abort_o[0] pulse, state OFF.
REQ-034 ch0 in GOING_OFF with cnt=7, force_i[0]=1 with force_val_i=1 for 10 cycles, then release -> ack_n_o[0]=1 while forced, then ack_n_o[0]=0 and cnt resumes from 7; ack_n_o[0] rises 8 edges after release.
REQ-035 RST_ACK_N=2'b10, reset pulsed mid GOING_ON on ch0 -> ack_n_o=2'b10, busy_o=0, abort_o=0 after reset; ch0 retransitions per REQ-021.
REQ-036 Both channels switched at the same edge with ON_LAT={4,9} -> acks change at edges k+3 and k+8 respectively.
